// File: rtl/fp_to_linear_decoder.sv
// Iterative decoder from 8-bit FP {S, E[2:0], F[3:0]} to a 12-bit two's-complement
// value D = (-1)^S * F * 2^E. The magnitude is shifted one bit per cycle.
module fp_to_linear_decoder #(
  parameter bit STRICT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [3:0]  F,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] D,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CONV  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        err_r_q, err_r_d;
  logic [11:0] d_q, d_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      err_r_q     <= 1'b0;
      d_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      err_r_q     <= err_r_d;
      d_q         <= d_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    err_r_d     = err_r_q;
    d_d         = d_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = S;
          mag_d   = {8'b0, F};
          cnt_d   = E;
          err_r_d = (E != 3'd0) && !F[3];
          state_d = (E != 3'd0) ? SHIFT : CONV;
        end
      end
      SHIFT: begin
        mag_d = mag_q << 1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = CONV;
      end
      CONV: begin
        // Negating a zero magnitude wraps back to 12'h000, so -0 needs no special case.
        if (STRICT && err_r_q) d_d = '0;
        else                   d_d = sign_q ? (~mag_q + 12'd1) : mag_q;
        err_d       = err_r_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fp_to_linear_decoder.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized transactions against an arithmetic reference model.
module tb_fp_to_linear_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_ready;
  logic        in_ready, in_ready_s;
  logic        out_valid, out_valid_s;
  logic [11:0] D, D_s;
  logic        err, err_s;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  fp_to_linear_decoder #(.STRICT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .err(err)
  );

  fp_to_linear_decoder #(.STRICT(1'b1)) u_dut_strict (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .S(S), .E(E), .F(F), .out_valid(out_valid_s), .out_ready(out_ready),
    .D(D_s), .err(err_s)
  );

  typedef struct {
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [11:0] d;
    logic        er;
    logic [11:0] d_strict;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {err, D} from plain integer arithmetic.
  function automatic logic [12:0] model(input logic s, input logic [2:0] e,
                                        input logic [3:0] f, input bit strict);
    int   mag;
    int   val;
    logic er;
    mag = int'(f) * (1 << int'(e));
    er  = (e != 3'd0) && (f < 4'd8);
    val = s ? -mag : mag;
    if (strict && er) val = 0;
    return {er, val[11:0]};
  endfunction

  task automatic run(input logic s, input logic [2:0] e, input logic [3:0] f,
                     input int unsigned hold, input bit early,
                     input logic [11:0] xd, input logic xe, input logic [11:0] xds);
    int unsigned lat;
    check("in_ready_idle", {in_ready, in_ready_s}, 2'b11);
    S = s; E = e; F = f; in_valid = 1'b1; out_ready = early;
    tick();
    in_valid = 1'b0;
    S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
    check("in_ready_busy", {in_ready, in_ready_s}, 2'b00);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, 32'(e) + 1);
    check("out_valid_strict", out_valid_s, 1'b1);
    check("D", D, xd);
    check("err", err, xe);
    check("D_strict", D_s, xds);
    check("err_strict", err_s, xe);
    if (!early) begin
      for (int unsigned i = 0; i < hold; i++) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
        tick();
        check("hold_valid", out_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_D", D, xd);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_hs_valid", {out_valid, out_valid_s}, 2'b00);
    check("post_hs_in_ready", {in_ready, in_ready_s}, 2'b11);
    check("post_hs_D_kept", D, xd);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [12:0] m0, m1;
    logic        rs;
    logic [2:0]  re;
    logic [3:0]  rf;

    vecs[0] = '{1'b0, 3'd3, 4'b1101, 12'h068, 1'b0, 12'h068};
    vecs[1] = '{1'b1, 3'd7, 4'b1111, 12'h880, 1'b0, 12'h880};
    vecs[2] = '{1'b1, 3'd0, 4'b0000, 12'h000, 1'b0, 12'h000};
    vecs[3] = '{1'b1, 3'd0, 4'b1001, 12'hFF7, 1'b0, 12'hFF7};
    vecs[4] = '{1'b0, 3'd7, 4'b1000, 12'h400, 1'b0, 12'h400};
    vecs[5] = '{1'b1, 3'd5, 4'b0000, 12'h000, 1'b1, 12'h000};
    vecs[6] = '{1'b1, 3'd2, 4'b0011, 12'hFF4, 1'b1, 12'h000};
    vecs[7] = '{1'b0, 3'd4, 4'b1001, 12'h090, 1'b0, 12'h090};
    vecs[8] = '{1'b0, 3'd2, 4'b0101, 12'h014, 1'b1, 12'h000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    S = 1'b0; E = '0; F = '0;
    #12;
    check("reset_in_ready", {in_ready, in_ready_s}, 2'b11);
    check("reset_out_valid", {out_valid, out_valid_s}, 2'b00);
    check("reset_D", {D, D_s}, 24'h0);
    check("reset_err", {err, err_s}, 2'b00);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      run(vecs[i].s, vecs[i].e, vecs[i].f, 1, 1'b0, vecs[i].d, vecs[i].er, vecs[i].d_strict);

    // Backpressure with competing input traffic.
    run(1'b0, 3'd1, 4'b1000, 5, 1'b0, 12'h010, 1'b0, 12'h010);
    // out_ready held high from before out_valid.
    run(1'b1, 3'd3, 4'b1100, 0, 1'b1, 12'hFA0, 1'b0, 12'hFA0);

    // Leave a nonzero result registered, then abort a decode mid-SHIFT.
    run(1'b0, 3'd2, 4'b0101, 0, 1'b0, 12'h014, 1'b1, 12'h000);
    S = 1'b1; E = 3'd6; F = 4'b1010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {out_valid, out_valid_s}, 2'b00);
    check("abort_in_ready", {in_ready, in_ready_s}, 2'b11);
    check("abort_D", D, 12'h000);
    check("abort_err", err, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
    run(1'b0, 3'd4, 4'b1001, 0, 1'b0, 12'h090, 1'b0, 12'h090);

    for (int unsigned k = 0; k < 200; k++) begin
      rs = 1'($urandom);
      re = 3'($urandom);
      rf = 4'($urandom);
      m0 = model(rs, re, rf, 1'b0);
      m1 = model(rs, re, rf, 1'b1);
      run(rs, re, rf, $urandom_range(0, 3), 1'($urandom), m0[11:0], m0[12], m1[11:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
